// File: rtl/cmp_pkg.sv
// Shared definitions for the streaming comparator: relation encodings,
// stats FSM states and the width-independent relation evaluator.
package cmp_pkg;

  localparam int unsigned CMP_MODE_W = 3;
  // Operands are extended to this width before evaluation; WIDTH must not exceed it.
  localparam int unsigned CMP_MAX_W  = 64;

  localparam logic [CMP_MODE_W-1:0] CMP_EQ = 3'd0;
  localparam logic [CMP_MODE_W-1:0] CMP_NE = 3'd1;
  localparam logic [CMP_MODE_W-1:0] CMP_LT = 3'd2;
  localparam logic [CMP_MODE_W-1:0] CMP_LE = 3'd3;
  localparam logic [CMP_MODE_W-1:0] CMP_GT = 3'd4;
  localparam logic [CMP_MODE_W-1:0] CMP_GE = 3'd5;

  typedef enum logic {
    ST_EMPTY,
    ST_TRACKING
  } stats_state_t;

  // Operands must already be sign-extended (signed_en=1) or zero-extended.
  function automatic logic cmp_eval(input logic [CMP_MAX_W-1:0] a,
                                    input logic [CMP_MAX_W-1:0] b,
                                    input logic [CMP_MODE_W-1:0] mode,
                                    input logic signed_en);
    logic lt;
    logic eq;
    eq = (a == b);
    lt = signed_en ? ($signed(a) < $signed(b)) : (a < b);
    case (mode)
      CMP_EQ:  cmp_eval = eq;
      CMP_NE:  cmp_eval = !eq;
      CMP_LT:  cmp_eval = lt;
      CMP_LE:  cmp_eval = lt || eq;
      CMP_GT:  cmp_eval = !(lt || eq);
      CMP_GE:  cmp_eval = !lt;
      default: cmp_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational WIDTH-bit relation evaluator, signed or unsigned.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [CMP_MODE_W-1:0] mode,
  input  logic                  signed_en,
  output logic                  result
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [CMP_MAX_W-1:0]    a_sx;
  logic [CMP_MAX_W-1:0]    b_sx;
  logic [CMP_MAX_W-1:0]    a_zx;
  logic [CMP_MAX_W-1:0]    b_zx;
  logic [CMP_MAX_W-1:0]    ax;
  logic [CMP_MAX_W-1:0]    bx;

  assign a_s  = a;
  assign b_s  = b;
  assign a_sx = CMP_MAX_W'(a_s);
  assign b_sx = CMP_MAX_W'(b_s);
  assign a_zx = CMP_MAX_W'(a);
  assign b_zx = CMP_MAX_W'(b);

  always_comb begin
    ax     = signed_en ? a_sx : a_zx;
    bx     = signed_en ? b_sx : b_zx;
    result = cmp_eval(ax, bx, mode, signed_en);
  end

endmodule

// File: rtl/cmp_stream_unit.sv
// Pipelined valid/ready comparator with legacy mask output and per-segment
// min/max/true-count statistics.
module cmp_stream_unit
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [CMP_MODE_W-1:0] mode,
  input  logic                  signed_en,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  result,
  output logic [WIDTH-1:0]      mask,
  output logic [WIDTH-1:0]      max_a,
  output logic [WIDTH-1:0]      min_a,
  output logic                  stats_valid,
  output logic [CNT_W-1:0]      true_count
);

  logic             accept;
  logic             rel;
  logic             a_gt_max;
  logic             a_lt_min;
  stats_state_t     state_q, state_n;
  logic [WIDTH-1:0] max_q, max_n;
  logic [WIDTH-1:0] min_q, min_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  cmp_core #(.WIDTH(WIDTH)) u_rel (
    .a        (a),
    .b        (b),
    .mode     (mode),
    .signed_en(signed_en),
    .result   (rel)
  );

  // Extremes are compared with the incoming pair's own signedness.
  cmp_core #(.WIDTH(WIDTH)) u_max (
    .a        (a),
    .b        (max_q),
    .mode     (CMP_GT),
    .signed_en(signed_en),
    .result   (a_gt_max)
  );

  cmp_core #(.WIDTH(WIDTH)) u_min (
    .a        (a),
    .b        (min_q),
    .mode     (CMP_LT),
    .signed_en(signed_en),
    .result   (a_lt_min)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= rel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign mask = {WIDTH{result}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      max_q   <= max_n;
      min_q   <= min_n;
      cnt_q   <= cnt_n;
    end
  end

  // A clear coinciding with an accept restarts the segment with that pair.
  always_comb begin
    state_n = state_q;
    max_n   = max_q;
    min_n   = min_q;
    cnt_n   = cnt_q;
    if (accept) begin
      state_n = ST_TRACKING;
      if (state_q == ST_EMPTY || clear) begin
        max_n = a;
        min_n = a;
        cnt_n = CNT_W'(rel);
      end else begin
        if (a_gt_max) max_n = a;
        if (a_lt_min) min_n = a;
        if (cnt_q != '1) cnt_n = cnt_q + CNT_W'(rel);
      end
    end else if (clear) begin
      state_n = ST_EMPTY;
      max_n   = '0;
      min_n   = '0;
      cnt_n   = '0;
    end
  end

  assign stats_valid = (state_q == ST_TRACKING);
  assign max_a       = max_q;
  assign min_a       = min_q;
  assign true_count  = cnt_q;

endmodule

// File: tb/tb_cmp_stream_unit.sv
// Self-checking bench for cmp_stream_unit: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_cmp_stream_unit;

  logic       clk = 1'b0;
  logic       reset, in_valid, signed_en, clear, out_ready;
  logic [7:0] a, b;
  logic [2:0] mode;

  logic       in_ready, out_valid, result, stats_valid;
  logic [7:0] mask, max_a, min_a, true_count;
  logic       in_ready_2, out_valid_2, result_2, stats_valid_2;
  logic [7:0] mask_2, max_a_2, min_a_2;
  logic [1:0] true_count_2;

  int checks = 0;
  int errs   = 0;

  // reference model state
  logic       m_ov, m_res, m_sv;
  logic [7:0] m_max, m_min;
  int         m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  cmp_stream_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .signed_en(signed_en), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .mask(mask),
    .max_a(max_a), .min_a(min_a), .stats_valid(stats_valid), .true_count(true_count)
  );

  cmp_stream_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_2),
    .a(a), .b(b), .mode(mode), .signed_en(signed_en), .clear(clear),
    .out_valid(out_valid_2), .out_ready(out_ready), .result(result_2), .mask(mask_2),
    .max_a(max_a_2), .min_a(min_a_2), .stats_valid(stats_valid_2), .true_count(true_count_2)
  );

  function automatic int sval(input logic [7:0] v, input logic s);
    return (s && v[7]) ? int'(v) - 256 : int'(v);
  endfunction

  function automatic logic relation(input logic [7:0] x, input logic [7:0] y,
                                    input logic [2:0] m, input logic s);
    int xi, yi;
    xi = sval(x, s);
    yi = sval(y, s);
    case (m)
      3'd0: return xi == yi;
      3'd1: return xi != yi;
      3'd2: return xi <  yi;
      3'd3: return xi <= yi;
      3'd4: return xi >  yi;
      3'd5: return xi >= yi;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_tick();
    logic acc, r;
    if (reset) begin
      m_ov = 0; m_res = 0; m_sv = 0; m_max = 0; m_min = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      r   = relation(a, b, mode, signed_en);
      if (acc) begin
        if (!m_sv || clear) begin
          m_max = a; m_min = a; m_cnt8 = int'(r); m_cnt2 = int'(r);
        end else begin
          if (sval(a, signed_en) > sval(m_max, signed_en)) m_max = a;
          if (sval(a, signed_en) < sval(m_min, signed_en)) m_min = a;
          m_cnt8 = (m_cnt8 + int'(r) > 255) ? 255 : m_cnt8 + int'(r);
          m_cnt2 = (m_cnt2 + int'(r) > 3) ? 3 : m_cnt2 + int'(r);
        end
        m_sv = 1;
      end else if (clear) begin
        m_max = 0; m_min = 0; m_cnt8 = 0; m_cnt2 = 0; m_sv = 0;
      end
      if (acc) begin
        m_ov = 1; m_res = r;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] m, input logic s);
    in_valid = v; a = av; b = bv; mode = m; signed_en = s;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; clear = 0; out_ready = 1;
    drive(0, 8'h00, 8'h00, 3'd0, 0);
    step(); step();
    checks++;
    if ({out_valid, result, mask, max_a, min_a, stats_valid, true_count, in_ready, true_count_2}
        !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 2'd0}) begin
      errs++;
      $display("FAIL reset: ov=%b res=%b mask=%h max=%h min=%h sv=%b cnt=%0d rdy=%b, want all zero with rdy=1",
               out_valid, result, mask, max_a, min_a, stats_valid, true_count, in_ready);
    end
    reset = 0;
  endtask

  task automatic test_legacy_ge();
    drive(1, 8'h10, 8'h10, 3'd5, 0);
    step();
    in_valid = 0;
    checks++;
    if ({out_valid, result, mask, true_count, min_a, max_a, stats_valid}
        !== {1'b1, 1'b1, 8'hFF, 8'd1, 8'h10, 8'h10, 1'b1}) begin
      errs++;
      $display("FAIL legacy_ge: ov=%b res=%b mask=%h cnt=%0d min=%h max=%h sv=%b, want 1 1 ff 1 10 10 1",
               out_valid, result, mask, true_count, min_a, max_a, stats_valid);
    end
  endtask

  task automatic test_signedness();
    logic [7:0] want_mask;
    for (int m = 0; m < 8; m++) begin
      for (int s = 0; s < 2; s++) begin
        drive(1, 8'h80, 8'h7F, 3'(m), 1'(s));
        step();
        want_mask = relation(8'h80, 8'h7F, 3'(m), 1'(s)) ? 8'hFF : 8'h00;
        checks++;
        if ({result, mask} !== {want_mask[0], want_mask}) begin
          errs++;
          $display("FAIL sign_sweep m=%0d s=%0d: res=%b mask=%h, want %b %h",
                   m, s, result, mask, want_mask[0], want_mask);
        end
      end
    end
    drive(1, 8'h80, 8'h7F, 3'd2, 1);
    step();
    checks++;
    if ({result, mask} !== {1'b1, 8'hFF}) begin
      errs++;
      $display("FAIL lt_signed: res=%b mask=%h, want 1 ff", result, mask);
    end
    drive(1, 8'h80, 8'h7F, 3'd2, 0);
    step();
    checks++;
    if ({result, mask} !== {1'b0, 8'h00}) begin
      errs++;
      $display("FAIL lt_unsigned: res=%b mask=%h, want 0 00", result, mask);
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(1, 8'h01, 8'h02, 3'd2, 0);
    step();
    drive(1, 8'h03, 8'h01, 3'd2, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({in_ready, out_valid, result, mask} !== {1'b0, 1'b1, 1'b1, 8'hFF}) begin
        errs++;
        $display("FAIL stall_hold[%0d]: rdy=%b ov=%b res=%b mask=%h, want 0 1 1 ff",
                 i, in_ready, out_valid, result, mask);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_comb: rdy=%b, want 1", in_ready);
    end
    step();
    in_valid = 0;
    checks++;
    if ({out_valid, result, mask} !== {1'b1, 1'b0, 8'h00}) begin
      errs++;
      $display("FAIL second_result: ov=%b res=%b mask=%h, want 1 0 00", out_valid, result, mask);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain: ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_minmax();
    logic [7:0] seq [4] = '{8'd5, 8'd250, 8'd3, 8'd9};
    for (int s = 0; s < 2; s++) begin
      clear = 1; in_valid = 0;
      step();
      clear = 0;
      checks++;
      if ({stats_valid, true_count} !== {1'b0, 8'd0}) begin
        errs++;
        $display("FAIL clear_alone: sv=%b cnt=%0d, want 0 0", stats_valid, true_count);
      end
      foreach (seq[i]) begin
        drive(1, seq[i], 8'd9, 3'd0, 1'(s));
        step();
      end
      in_valid = 0;
      checks++;
      if (s == 0 && {max_a, min_a, true_count} !== {8'd250, 8'd3, 8'd1}) begin
        errs++;
        $display("FAIL minmax_u: max=%0d min=%0d cnt=%0d, want 250 3 1", max_a, min_a, true_count);
      end else if (s == 1 && {max_a, min_a, true_count} !== {8'd9, 8'd250, 8'd1}) begin
        errs++;
        $display("FAIL minmax_s: max=%0d min=%0d cnt=%0d, want 9 250 1", max_a, min_a, true_count);
      end
    end
  endtask

  task automatic test_clear_accept();
    clear = 1;
    drive(1, 8'h42, 8'h42, 3'd0, 0);
    step();
    clear = 0; in_valid = 0;
    checks++;
    if ({max_a, min_a, true_count, stats_valid, result} !== {8'h42, 8'h42, 8'd1, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL clear_accept: max=%h min=%h cnt=%0d sv=%b res=%b, want 42 42 1 1 1",
               max_a, min_a, true_count, stats_valid, result);
    end
    clear = 1;
    step();
    clear = 0;
    checks++;
    if ({stats_valid, true_count, max_a, min_a, result} !== {1'b0, 8'd0, 8'h00, 8'h00, 1'b1}) begin
      errs++;
      $display("FAIL clear_only: sv=%b cnt=%0d max=%h min=%h res=%b, want 0 0 00 00 1",
               stats_valid, true_count, max_a, min_a, result);
    end
  endtask

  task automatic test_saturation();
    clear = 1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(20 + i), 8'd7, 3'd5, 0);
      step();
      clear = 0;
    end
    in_valid = 0;
    checks++;
    if ({true_count_2, true_count} !== {2'd3, 8'd5}) begin
      errs++;
      $display("FAIL saturate: cnt2=%0d cnt8=%0d, want 3 5", true_count_2, true_count);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 0;
    drive(1, 8'h01, 8'h00, 3'd4, 0);
    step(); step();
    reset = 1;
    step();
    checks++;
    if ({out_valid, result, mask, max_a, min_a, stats_valid, true_count, in_ready, true_count_2}
        !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 2'd0}) begin
      errs++;
      $display("FAIL reset_stall: ov=%b res=%b mask=%h max=%h min=%h sv=%b cnt=%0d rdy=%b, want zeros rdy=1",
               out_valid, result, mask, max_a, min_a, stats_valid, true_count, in_ready);
    end
    reset = 0; in_valid = 0; out_ready = 1;
    step();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clear     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) b = a;
      step();
      checks++;
      if ({in_ready, out_valid, result, mask, max_a, min_a, stats_valid, true_count, true_count_2}
          !== {!m_ov || out_ready, m_ov, m_res, {8{m_res}}, m_max, m_min, m_sv, 8'(m_cnt8), 2'(m_cnt2)}) begin
        errs++;
        if (bad < 10)
          $display("FAIL random[%0d]: rdy=%b ov=%b res=%b max=%h min=%h sv=%b cnt=%0d cnt2=%0d, want %b %b %b %h %h %b %0d %0d",
                   i, in_ready, out_valid, result, max_a, min_a, stats_valid, true_count, true_count_2,
                   !m_ov || out_ready, m_ov, m_res, m_max, m_min, m_sv, m_cnt8, m_cnt2);
        bad++;
      end
    end
    reset = 0; clear = 0; in_valid = 0;
  endtask

  initial begin
    m_ov = 0; m_res = 0; m_sv = 0; m_max = 0; m_min = 0; m_cnt8 = 0; m_cnt2 = 0;
    test_reset();
    test_legacy_ge();
    test_signedness();
    test_backpressure();
    test_minmax();
    test_clear_accept();
    test_saturation();
    test_reset_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule

// File: doc/cmp_stream_unit.md
Name: cmp_stream_unit

Overview:
Parametrised, pipelined successor to the team's 8-bit A>=B mask comparator. It accepts operand pairs over a valid/ready stream and evaluates one of six selectable relations, signed or unsigned. Each result is returned as a 1-bit flag and as a legacy all-ones/all-zeros mask. Running min/max of A and a count of true results are tracked per stream segment. It sits between the datapath register file and the lab display/ALU logic.

Parameters:
WIDTH, 8, operand and mask width in bits (>=2)
CNT_W, 8, width of the saturating true-result counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
mode  in  3  relation select (encoding below)
signed_en  in  1  1 = two's-complement compare, 0 = unsigned
clear  in  1  restart statistics segment
out_valid  out  1  result register holds valid data
out_ready  in  1  downstream accepts result
result  out  1  relation outcome
mask  out  WIDTH  all ones if result=1, else all zeros
max_a  out  WIDTH  largest A accepted in segment
min_a  out  WIDTH  smallest A accepted in segment
stats_valid  out  1  at least one pair accepted in segment
true_count  out  CNT_W  number of accepted pairs with result=1, saturating

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, result=0, mask=0, max_a=0, min_a=0, stats_valid=0, true_count=0, FSM->EMPTY. Reset overrides every other input, including mid-stream and during stall.
- Mode encoding: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved -> result=0. Mode 5 with signed_en=0 reproduces the legacy comparator.
- Signed compare interprets a, b as two's complement. Example, WIDTH=8: 0x80 < 0x7F signed, 0x80 > 0x7F unsigned.
- Handshake: accept = in_valid && in_ready. in_ready = !out_valid || out_ready, combinational from out_ready, so there are no bubbles at full throughput.
- Latency: a pair accepted at edge N gives result/mask/out_valid from edge N+1. The values are held stable while out_valid && !out_ready. out_valid drops only when out_ready=1 and no new accept occurs in that cycle.
- Output register is loaded only on accept. It is never altered by clear.
- Stats FSM states:
  - EMPTY: stats_valid=0. On accept: max_a=min_a=a, true_count=result of that pair, go to TRACKING.
  - TRACKING: on accept: max_a/min_a updated using the same signedness as that pair's signed_en; true_count += result, saturating at 2^CNT_W-1; stay in TRACKING.
- clear=1 without accept: max_a=0, min_a=0, true_count=0, go to EMPTY.
- clear=1 with accept in the same cycle: the segment restarts with that pair, i.e. EMPTY-accept behaviour applied. clear never blocks in_ready.
- Stats outputs update at the same edge as the result register, so there is no extra latency.
- Inputs a, b, mode and signed_en are sampled only on accept. They are don't-care otherwise.

Decomposition:
- Shared package cmp_pkg: mode localparams (CMP_EQ..CMP_GE), the 3-bit mode width constant, and a function cmp_eval(a, b, mode, signed_en) returning 1 bit.
- One sub-module, cmp_core: purely combinational, WIDTH-parametrised relation evaluator. It is instantiated once for result and used, via function or second instance, for the min/max updates.
- Top level holds the output register, the handshake and the stats FSM.

Test Plan:
- Reset, then WIDTH=8, mode=5, signed_en=0, a=0x10, b=0x10, out_ready=1 -> next cycle out_valid=1, result=1, mask=0xFF, true_count=1, min_a=max_a=0x10, stats_valid=1.
- Signedness sweep with a=0x80, b=0x7F: mode=2 (LT), signed_en=1 -> result=1, mask=0xFF. Same pair, signed_en=0 -> result=0, mask=0x00. Modes 6/7 -> result=0.
- Backpressure: out_ready=0 after the first accept, second pair presented -> in_ready=0, first result held unchanged for 3 cycles. Raise out_ready -> second pair accepted the same cycle, its result appears next edge.
- Stream of A=5,250,3,9 (unsigned, mode=0 against b=9) -> max_a=250, min_a=3, true_count=1. Same A values signed -> max_a=9, min_a=250 (-6).
- Clear coinciding with accept of a=0x42 (result=1) -> stats restart: max_a=min_a=0x42, true_count=1, stats_valid=1. Clear alone -> stats_valid=0, count=0.
- CNT_W=2, five consecutive true results -> true_count sticks at 3. Assert reset mid-stall -> all outputs 0 next edge, in_ready=1.
